// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver that feeds a small byte FIFO, drained by word reads over a valid/ready bus.
// The response arrives 1 cycle after the request. There is no backpressure: a byte that arrives while the FIFO is full is dropped and the overrun flag is set.
module uart_rx_fifo #(
    parameter int clks_per_bit = 216,
    parameter int fifo_depth   = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        uart_rx,
    input  logic        uart_valid,
    input  logic [3:0]  uart_wstrb,
    output logic [31:0] uart_rdata,
    output logic        uart_ready,
    output logic        uart_irq
);

    localparam int cnt_w  = $clog2(clks_per_bit + 1);
    localparam int addr_w = $clog2(fifo_depth);
    localparam logic [cnt_w-1:0] bit_end   = cnt_w'(clks_per_bit);
    localparam logic [cnt_w-1:0] start_mid = cnt_w'(clks_per_bit / 2);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t            state, state_nx;
    logic [cnt_w-1:0]  cnt, cnt_nx;
    logic [2:0]        bit_idx, bit_idx_nx;
    logic [7:0]        shift, shift_nx;
    logic              push, frame_err;
    logic              rx_meta, rxs;

    logic [7:0]        mem [fifo_depth];
    logic [addr_w:0]   wptr, rptr;
    logic              empty, full, rd_req, pop, push_ok, overrun_evt;
    logic              fe_flag, ov_flag;
    logic [7:0]        head;

    always_ff @(posedge clock) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rxs     <= rx_meta;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            bit_idx <= bit_idx_nx;
            shift   <= shift_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt + 1'b1;
        bit_idx_nx = bit_idx;
        shift_nx   = shift;
        push       = 1'b0;
        frame_err  = 1'b0;
        case (state)
            IDLE: begin
                cnt_nx = '0;
                if (!rxs) state_nx = START;
            end
            START: begin
                // Re-check the start bit mid-way to reject short glitches.
                if (cnt == start_mid) begin
                    cnt_nx     = '0;
                    bit_idx_nx = '0;
                    state_nx   = rxs ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == bit_end) begin
                    cnt_nx            = '0;
                    shift_nx[bit_idx] = rxs;
                    if (bit_idx == 3'd7) state_nx = STOP;
                    else                 bit_idx_nx = bit_idx + 1'b1;
                end
            end
            STOP: begin
                if (cnt == bit_end) begin
                    cnt_nx    = '0;
                    state_nx  = IDLE;
                    push      = rxs;
                    frame_err = ~rxs;
                end
            end
            default: begin
                cnt_nx   = '0;
                state_nx = IDLE;
            end
        endcase
    end

    assign empty  = (wptr == rptr);
    assign full   = (wptr[addr_w] != rptr[addr_w]) &&
                    (wptr[addr_w-1:0] == rptr[addr_w-1:0]);
    assign head   = mem[rptr[addr_w-1:0]];
    assign rd_req = uart_valid && (uart_wstrb == 4'd0);
    assign pop    = rd_req && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign push_ok     = push && (!full || pop);
    assign overrun_evt = push && full && !pop;

    always_ff @(posedge clock) begin
        if (!reset && push_ok) mem[wptr[addr_w-1:0]] <= shift;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wptr       <= '0;
            rptr       <= '0;
            fe_flag    <= 1'b0;
            ov_flag    <= 1'b0;
            uart_ready <= 1'b0;
            uart_rdata <= '0;
            uart_irq   <= 1'b0;
        end else begin
            if (push_ok) wptr <= wptr + 1'b1;
            if (pop)     rptr <= rptr + 1'b1;
            fe_flag    <= frame_err   | (fe_flag & ~rd_req);
            ov_flag    <= overrun_evt | (ov_flag & ~rd_req);
            uart_ready <= uart_valid;
            if (uart_valid) begin
                uart_rdata <= rd_req ? {21'd0, ov_flag, fe_flag, ~empty, (empty ? 8'h00 : head)}
                                     : 32'd0;
            end
            uart_irq   <= ~empty;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed vector table, hand-written corner sequences, then random frames
// checked against a queue-based model of the receive FIFO and its error flags.
module tb_uart_rx_fifo;

    localparam int cpb   = 15;
    localparam int depth = 4;
    localparam int bit_cycles = cpb + 1;

    logic        clock = 1'b0;
    logic        reset;
    logic        uart_rx;
    logic        uart_valid;
    logic [3:0]  uart_wstrb;
    logic [31:0] uart_rdata;
    logic        uart_ready;
    logic        uart_irq;

    int total = 0;
    int bad   = 0;

    uart_rx_fifo #(.clks_per_bit(cpb), .fifo_depth(depth)) dut (
        .clock      (clock),
        .reset      (reset),
        .uart_rx    (uart_rx),
        .uart_valid (uart_valid),
        .uart_wstrb (uart_wstrb),
        .uart_rdata (uart_rdata),
        .uart_ready (uart_ready),
        .uart_irq   (uart_irq)
    );

    always #5 clock = ~clock;

    typedef enum {OP_FRAME, OP_READ, OP_WRITE, OP_GLITCH} op_e;
    typedef struct {
        op_e         op;
        logic [7:0]  dat;
        logic        stp;
        logic [31:0] exp;
        logic        exp_irq;
        logic        chk_rise;
    } vec_t;

    vec_t vecs[18];

    // reference model state
    logic [7:0] mq[$];
    logic       m_fe;
    logic       m_ov;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_read();
        logic [31:0] r;
        r = {21'd0, m_ov, m_fe, 1'b0, 8'h00};
        if (mq.size() > 0) begin
            r[8]   = 1'b1;
            r[7:0] = mq.pop_front();
        end
        m_fe = 1'b0;
        m_ov = 1'b0;
        return r;
    endfunction

    function automatic void model_frame(input logic [7:0] d, input logic stp);
        if (!stp)                  m_fe = 1'b1;
        else if (mq.size() == depth) m_ov = 1'b1;
        else                       mq.push_back(d);
    endfunction

    // One 8N1 frame, line changes right after a clock edge. Optional read issued at
    // frame cycle rd_at, optional reset pulse at frame cycle abort_at.
    task automatic send_frame(input logic [7:0] dat, input logic stp, input int rd_at,
                              input int abort_at, output logic [31:0] rsp,
                              output logic rsp_rdy, output logic irq_pre, output logic irq_post);
        logic [9:0] sh;
        sh       = {stp, dat, 1'b0};
        rsp      = '0;
        rsp_rdy  = 1'b0;
        irq_pre  = 1'b0;
        irq_post = 1'b0;
        for (int n = 0; n < 10 * bit_cycles; n++) begin
            if (n == abort_at) begin
                reset   = 1'b1;
                uart_rx = 1'b1;
                tick();
                tick();
                reset = 1'b0;
                return;
            end
            if (n > 0 && (n % bit_cycles) == 0) sh = sh >> 1;
            uart_rx = sh[0];
            if (n == rd_at) begin
                uart_valid = 1'b1;
                uart_wstrb = 4'd0;
            end
            if (n == rd_at + 1) begin
                uart_valid = 1'b0;
                rsp        = uart_rdata;
                rsp_rdy    = uart_ready;
            end
            if (n == 155) irq_pre  = uart_irq;
            if (n == 157) irq_post = uart_irq;
            tick();
        end
        uart_rx = 1'b1;
        tick();
        tick();
    endtask

    task automatic bus_access(input logic [3:0] strb, output logic [31:0] rd, output logic rdy,
                              output logic rdy_after, output logic irq_after);
        uart_valid = 1'b1;
        uart_wstrb = strb;
        tick();
        uart_valid = 1'b0;
        uart_wstrb = 4'd0;
        rd  = uart_rdata;
        rdy = uart_ready;
        tick();
        rdy_after = uart_ready;
        irq_after = uart_irq;
    endtask

    task automatic glitch();
        uart_rx = 1'b0;
        repeat (5) tick();
        uart_rx = 1'b1;
        repeat (20) tick();
    endtask

    task automatic read_expect(input string name, input logic [31:0] exp);
        logic [31:0] rd;
        logic rdy, rdy2, irq2;
        bus_access(4'd0, rd, rdy, rdy2, irq2);
        check({name, "_rdata"}, rd, exp);
        check({name, "_ready"}, {31'd0, rdy}, 32'd1);
        check({name, "_ready_drop"}, {31'd0, rdy2}, 32'd0);
    endtask

    initial begin
        logic [31:0] rsp, rd;
        logic rdy, rdy2, irq2, ip, iq;
        int rd_at;
        logic [7:0] d;
        logic stp;
        logic [31:0] exp_mid;

        vecs[0]  = '{OP_FRAME,  8'hA5, 1'b1, 32'h0,   1'b1, 1'b1};
        vecs[1]  = '{OP_READ,   8'h00, 1'b0, 32'h1A5, 1'b0, 1'b0};
        vecs[2]  = '{OP_GLITCH, 8'h00, 1'b0, 32'h0,   1'b0, 1'b0};
        vecs[3]  = '{OP_READ,   8'h00, 1'b0, 32'h000, 1'b0, 1'b0};
        vecs[4]  = '{OP_FRAME,  8'h3C, 1'b0, 32'h0,   1'b0, 1'b0};
        vecs[5]  = '{OP_READ,   8'h00, 1'b0, 32'h200, 1'b0, 1'b0};
        vecs[6]  = '{OP_READ,   8'h00, 1'b0, 32'h000, 1'b0, 1'b0};
        vecs[7]  = '{OP_FRAME,  8'h01, 1'b1, 32'h0,   1'b1, 1'b1};
        vecs[8]  = '{OP_FRAME,  8'h02, 1'b1, 32'h0,   1'b1, 1'b0};
        vecs[9]  = '{OP_FRAME,  8'h03, 1'b1, 32'h0,   1'b1, 1'b0};
        vecs[10] = '{OP_FRAME,  8'h04, 1'b1, 32'h0,   1'b1, 1'b0};
        vecs[11] = '{OP_FRAME,  8'h05, 1'b1, 32'h0,   1'b1, 1'b0};
        vecs[12] = '{OP_READ,   8'h00, 1'b0, 32'h501, 1'b1, 1'b0};
        vecs[13] = '{OP_READ,   8'h00, 1'b0, 32'h102, 1'b1, 1'b0};
        vecs[14] = '{OP_READ,   8'h00, 1'b0, 32'h103, 1'b1, 1'b0};
        vecs[15] = '{OP_READ,   8'h00, 1'b0, 32'h104, 1'b0, 1'b0};
        vecs[16] = '{OP_READ,   8'h00, 1'b0, 32'h000, 1'b0, 1'b0};
        vecs[17] = '{OP_WRITE,  8'h00, 1'b0, 32'h000, 1'b0, 1'b0};

        reset      = 1'b1;
        uart_rx    = 1'b1;
        uart_valid = 1'b0;
        uart_wstrb = 4'd0;
        repeat (3) tick();
        check("reset_ready", {31'd0, uart_ready}, 32'd0);
        check("reset_rdata", uart_rdata, 32'd0);
        check("reset_irq",   {31'd0, uart_irq}, 32'd0);
        reset = 1'b0;
        repeat (3) tick();

        for (int i = 0; i < 18; i++) begin
            case (vecs[i].op)
                OP_FRAME: begin
                    send_frame(vecs[i].dat, vecs[i].stp, -1, -1, rsp, rdy, ip, iq);
                    if (vecs[i].chk_rise) begin
                        check($sformatf("v%0d_irq_before_push", i), {31'd0, ip}, 32'd0);
                        check($sformatf("v%0d_irq_rise", i),        {31'd0, iq}, 32'd1);
                    end
                    check($sformatf("v%0d_irq", i), {31'd0, uart_irq}, {31'd0, vecs[i].exp_irq});
                end
                OP_READ, OP_WRITE: begin
                    bus_access((vecs[i].op == OP_WRITE) ? 4'hF : 4'h0, rd, rdy, rdy2, irq2);
                    check($sformatf("v%0d_rdata", i), rd, vecs[i].exp);
                    check($sformatf("v%0d_ready", i), {31'd0, rdy}, 32'd1);
                    check($sformatf("v%0d_ready_drop", i), {31'd0, rdy2}, 32'd0);
                    check($sformatf("v%0d_irq", i), {31'd0, irq2}, {31'd0, vecs[i].exp_irq});
                end
                default: begin
                    glitch();
                    check($sformatf("v%0d_irq", i), {31'd0, uart_irq}, {31'd0, vecs[i].exp_irq});
                end
            endcase
        end

        // Full FIFO, read lands on the same cycle as the stop-bit sample of 0x77.
        send_frame(8'h11, 1'b1, -1, -1, rsp, rdy, ip, iq);
        send_frame(8'h22, 1'b1, -1, -1, rsp, rdy, ip, iq);
        send_frame(8'h33, 1'b1, -1, -1, rsp, rdy, ip, iq);
        send_frame(8'h44, 1'b1, -1, -1, rsp, rdy, ip, iq);
        send_frame(8'h77, 1'b1, 154, -1, rsp, rdy, ip, iq);
        check("simul_rdata", rsp, 32'h111);
        check("simul_ready", {31'd0, rdy}, 32'd1);
        read_expect("simul_r1", 32'h122);
        read_expect("simul_r2", 32'h133);
        read_expect("simul_r3", 32'h144);
        read_expect("simul_r4", 32'h177);
        read_expect("simul_r5", 32'h000);

        // Reset in the middle of data bit 4, then a clean frame and a write.
        send_frame(8'h00, 1'b1, -1, 85, rsp, rdy, ip, iq);
        check("midrst_ready", {31'd0, uart_ready}, 32'd0);
        check("midrst_rdata", uart_rdata, 32'd0);
        check("midrst_irq",   {31'd0, uart_irq}, 32'd0);
        uart_rx = 1'b1;
        repeat (5) tick();
        send_frame(8'h5A, 1'b1, -1, -1, rsp, rdy, ip, iq);
        bus_access(4'hF, rd, rdy, rdy2, irq2);
        check("write_rdata", rd, 32'd0);
        check("write_ready", {31'd0, rdy}, 32'd1);
        check("write_irq_kept", {31'd0, irq2}, 32'd1);
        read_expect("midrst_r1", 32'h15A);
        read_expect("midrst_r2", 32'h000);

        // Random frames, stop bits and read placement against the queue model.
        mq.delete();
        m_fe = 1'b0;
        m_ov = 1'b0;
        for (int it = 0; it < 16; it++) begin
            for (int k = 0; k < $urandom_range(0, 2); k++)
                read_expect($sformatf("rnd%0d_pre%0d", it, k), model_read());
            d     = 8'($urandom_range(0, 255));
            stp   = ($urandom_range(0, 4) != 0);
            rd_at = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 140)) : -1;
            exp_mid = 32'd0;
            if (rd_at >= 0) exp_mid = model_read();
            send_frame(d, stp, rd_at, -1, rsp, rdy, ip, iq);
            model_frame(d, stp);
            if (rd_at >= 0) begin
                check($sformatf("rnd%0d_mid_rdata", it), rsp, exp_mid);
                check($sformatf("rnd%0d_mid_ready", it), {31'd0, rdy}, 32'd1);
            end
            check($sformatf("rnd%0d_irq", it), {31'd0, uart_irq}, {31'd0, (mq.size() > 0)});
        end
        for (int k = 0; k < depth + 1; k++)
            read_expect($sformatf("rnd_drain%0d", k), model_read());

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- UART receive stage for the memory-mapped UART window at uart_base_addr (0x1000000).
- Consumes clks_per_bit (clk_freq/baudrate-1) from the system configuration package.
- Deserialises 8N1 frames from the external RX pin into a small receive FIFO.
- The core drains the FIFO through the same valid/ready word interface used by the other peripherals.

Parameters:
- clks_per_bit, 216: bit period minus one, in clock cycles. One bit lasts clks_per_bit+1 cycles. Must be >= 3.
- fifo_depth, 4: receive FIFO entries. Power of two, >= 2.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- uart_rx  in  1  asynchronous serial input, idle high.
- uart_valid  in  1  access request, single-cycle pulse.
- uart_wstrb  in  4  0 = read, any nonzero value = write.
- uart_rdata  out  32  read data. Valid only when uart_ready=1.
- uart_ready  out  1  access acknowledge, one-cycle pulse.
- uart_irq  out  1  high while the FIFO is non-empty.

Behaviour:
- Reset values:
  - uart_ready=0, uart_rdata=0, uart_irq=0.
  - FIFO empty; framing/overrun flags 0; FSM in IDLE.
  - Both synchroniser flops =1.
- Reset asserted mid-frame aborts the frame; the partial byte is discarded.
- RX input passes through a 2-flop synchroniser; rxs denotes the second flop. All sampling below uses rxs.
- Counter cnt is wide enough for clks_per_bit. It reloads to 0 on every state transition.
- FSM transitions:
  - IDLE: when rxs=0, go to START with cnt=0.
  - START: when cnt=clks_per_bit/2 (integer division), sample rxs.
    - rxs=1: glitch; return to IDLE.
    - rxs=0: go to DATA, bit index 0.
  - DATA: when cnt=clks_per_bit, sample rxs into shift[index], LSB first, and reset cnt.
    - After index 7 is sampled, go to STOP.
  - STOP: when cnt=clks_per_bit, sample rxs.
    - rxs=1: push the byte.
    - rxs=0: set the framing flag and drop the byte.
    - In both cases go to IDLE in the same cycle, so a start bit is detected from the next cycle.
- Push onto a full FIFO:
  - If a pop does not occur in the same cycle: byte dropped, overrun flag set, FIFO contents unchanged.
  - If a pop occurs in the same cycle: the pop is applied first, then the push. No overrun.
- FIFO implementation: read/write pointers with an extra wrap bit. Full/empty derive from the pointers, with correct wrap-around at depth.
- Bus access: a request is sampled on uart_valid=1. uart_ready=1 exactly one cycle later with uart_rdata; uart_ready=0 otherwise. No back-to-back restriction.
- Read (uart_wstrb=0) returns:
  - [7:0] head byte, or 0 if the FIFO is empty.
  - [8] 1 if a byte was returned.
  - [9] framing flag.
  - [10] overrun flag.
  - [31:11] 0.
- Read side effects:
  - Pops the FIFO if non-empty; an empty read has no side effect on the FIFO.
  - Clears both flags at the cycle of the response.
  - A new error event in that same cycle wins: the flag remains 1.
- Write: acknowledged with uart_rdata=0. No effect on state.
- uart_irq is a registered copy of "FIFO non-empty", updated every cycle.

Test Plan:
- Frame decode: clks_per_bit=15, send 0xA5 with 16-cycle bits.
  - uart_irq rises 1-2 cycles after the stop-bit sample.
  - A read returns rdata=0x1A5; uart_irq then drops to 0.
- Glitch rejection: drive uart_rx low for 5 cycles (clks_per_bit=15).
  - FSM returns to IDLE; no push; a read returns 0x000.
- Framing error: send 0x3C with stop bit=0.
  - A read returns 0x200. A second read returns 0x000.
- Overrun: fifo_depth=4, send 0x01..0x05 without reading.
  - Reads return 0x501, 0x102, 0x103, 0x104, 0x000. The overrun flag appears on the first read only.
- Simultaneous push/pop at full: FIFO holds 4 bytes; issue a read in the same cycle as the stop-bit sample of 0x77.
  - No overrun. The next reads return the remaining 3 bytes, then 0x177.
- Reset mid-frame, and write: assert reset during DATA bit 4, then send 0x5A.
  - A read returns 0x15A only.
  - A write with wstrb=0xF gives ready after 1 cycle, rdata=0, and FIFO unchanged.
